// File: rtl/point_verify_pkg.sv
// Shared definitions for the on-curve checker: default field width and FSM state encoding.
package point_verify_pkg;

  localparam int N_DEFAULT = 530;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_MUL_YY,
    S_MUL_XX,
    S_ADD_A,
    S_MUL_X,
    S_ADD_B,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/mod_mul_iter.sv
// Iterative MSB-first modular multiplier: one load cycle, then n double-and-add steps.
// Requires op_a < p and p < 2^(n-1); done and result are valid together in the final step cycle.
module mod_mul_iter
  import point_verify_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] op_a,
  input  logic [n-1:0] op_b,
  input  logic [n-1:0] p,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n + 1);

  logic [n-1:0]  acc;
  logic [n-1:0]  a_r;
  logic [n-1:0]  b_r;
  logic [CW-1:0] cnt;
  logic          running;

  function automatic logic [n-1:0] mod_step(input logic [n-1:0] acc_in,
                                            input logic [n-1:0] add,
                                            input logic [n-1:0] m,
                                            input logic         bit_set);
    logic [n-1:0] dbl;
    logic [n-1:0] sum;
    // acc_in < m < 2^(n-1), so doubling cannot overflow n bits
    dbl = {acc_in[n-2:0], 1'b0};
    if (dbl >= m) dbl = dbl - m;
    sum = bit_set ? dbl + add : dbl;
    if (sum >= m) sum = sum - m;
    return sum;
  endfunction

  assign result = mod_step(acc, a_r, p, b_r[n-1]);
  assign done   = running && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start && !running) begin
      acc     <= '0;
      a_r     <= op_a;
      b_r     <= op_b;
      cnt     <= CW'(n);
      running <= 1'b1;
    end else if (running) begin
      acc <= result;
      b_r <= {b_r[n-2:0], 1'b0};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/point_verify.sv
// Sequential check of y^2 == x^3 + a*x + b (mod p) for an affine short-Weierstrass point.
// Optional failed-check counter enabled by defining POINT_VERIFY_ERRCNT_EN.
module point_verify
  import point_verify_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         inf_in,
  output logic         busy,
  output logic         done,
  output logic         on_curve,
  output logic         invalid,
  output logic [15:0]  err_count
);

  state_t       state;
  logic [n-1:0] p_r, a_r, b_r, x_r, y_r;
  logic         inf_r;
  logic [n-1:0] t1, t2, t3;
  logic         mul_start;
  logic         mul_done;
  logic [n-1:0] mul_res;
  logic [n-1:0] op_a, op_b;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] u,
                                           input logic [n-1:0] v,
                                           input logic [n-1:0] m);
    logic [n:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[n-1:0];
  endfunction

  // Operands are only sampled in the multiplier's load cycle, the first cycle of each MUL state
  always_comb begin
    op_a = y_r;
    op_b = y_r;
    case (state)
      S_MUL_XX: begin op_a = x_r; op_b = x_r; end
      S_MUL_X:  begin op_a = t2;  op_b = x_r; end
      default:  begin op_a = y_r; op_b = y_r; end
    endcase
  end

  mod_mul_iter #(.n(n)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .op_a   (op_a),
    .op_b   (op_b),
    .p      (p_r),
    .done   (mul_done),
    .result (mul_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      p_r       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      inf_r     <= 1'b0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      on_curve  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          p_r      <= p;
          a_r      <= a;
          b_r      <= b;
          x_r      <= x;
          y_r      <= y;
          inf_r    <= inf_in;
          on_curve <= 1'b0;
          invalid  <= 1'b0;
          busy     <= 1'b1;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (inf_r) begin
            on_curve <= 1'b1;
            state    <= S_DONE;
          end else if (x_r >= p_r || y_r >= p_r) begin
            invalid <= 1'b1;
            state   <= S_DONE;
          end else begin
            mul_start <= 1'b1;
            state     <= S_MUL_YY;
          end
        end
        S_MUL_YY: if (mul_done) begin
          t1        <= mul_res;
          mul_start <= 1'b1;
          state     <= S_MUL_XX;
        end
        S_MUL_XX: if (mul_done) begin
          t2    <= mul_res;
          state <= S_ADD_A;
        end
        S_ADD_A: begin
          t2        <= mod_add(t2, a_r, p_r);
          mul_start <= 1'b1;
          state     <= S_MUL_X;
        end
        S_MUL_X: if (mul_done) begin
          t3    <= mul_res;
          state <= S_ADD_B;
        end
        S_ADD_B: begin
          t3    <= mod_add(t3, b_r, p_r);
          state <= S_CMP;
        end
        S_CMP: begin
          on_curve <= (t1 == t3);
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef POINT_VERIFY_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (state == S_DONE && !on_curve && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_point_verify.sv
// Directed bench for point_verify: small curve y^2 = x^3 + x + 1 mod 23 at n=8, and P-521 at n=530.
module tb_point_verify;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  x_s, y_s;
  logic        start_s, inf_s;
  logic        busy_s, done_s, on_curve_s, invalid_s;
  logic [15:0] err_s;

  logic [529:0] p_b, a_b, b_b, x_b, y_b;
  logic         start_b;
  logic         busy_b, done_b, on_curve_b, invalid_b;
  logic [15:0]  err_b;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;

  point_verify #(.n(8)) dut_s (
    .clk(clk), .reset(reset), .start(start_s),
    .p(8'd23), .a(8'd1), .b(8'd1), .x(x_s), .y(y_s), .inf_in(inf_s),
    .busy(busy_s), .done(done_s), .on_curve(on_curve_s), .invalid(invalid_s),
    .err_count(err_s)
  );

  point_verify #(.n(530)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .p(p_b), .a(a_b), .b(b_b), .x(x_b), .y(y_b), .inf_in(1'b0),
    .busy(busy_b), .done(done_b), .on_curve(on_curve_b), .invalid(invalid_b),
    .err_count(err_b)
  );

  // Drives one request into the small instance and reports the done latency and results
  task automatic run_small(input logic [7:0] xi, input logic [7:0] yi, input logic infi,
                           output int lat, output logic oc, output logic inv);
    @(negedge clk);
    x_s = xi; y_s = yi; inf_s = infi; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done_s) begin lat = k; break; end
    end
    oc = on_curve_s;
    inv = invalid_s;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_s = 1'b0; start_b = 1'b0; inf_s = 1'b0; x_s = '0; y_s = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy_s !== 1'b0) begin $display("FAIL reset_busy: got %b, expected 0", busy_s); fails++; end
    tests++; if (done_s !== 1'b0) begin $display("FAIL reset_done: got %b, expected 0", done_s); fails++; end
    tests++; if (on_curve_s !== 1'b0 || invalid_s !== 1'b0) begin
      $display("FAIL reset_results: got on_curve=%b invalid=%b, expected 0 0", on_curve_s, invalid_s); fails++; end
    tests++; if (err_s !== 16'd0) begin $display("FAIL reset_err_count: got %0d, expected 0", err_s); fails++; end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_on_curve;
    int lat; logic oc, inv;
    run_small(8'd3, 8'd10, 1'b0, lat, oc, inv);
    tests++; if (lat !== 32) begin $display("FAIL case1_latency: got %0d, expected 32", lat); fails++; end
    tests++; if (oc !== 1'b1) begin $display("FAIL case1_on_curve: got %b, expected 1", oc); fails++; end
    tests++; if (inv !== 1'b0) begin $display("FAIL case1_invalid: got %b, expected 0", inv); fails++; end
    @(posedge clk); #1;
    tests++; if (done_s !== 1'b0 || on_curve_s !== 1'b1) begin
      $display("FAIL case1_hold: got done=%b on_curve=%b, expected 0 1", done_s, on_curve_s); fails++; end
  endtask

  task automatic test_off_curve;
    int lat; logic oc, inv;
    run_small(8'd3, 8'd11, 1'b0, lat, oc, inv);
`ifdef POINT_VERIFY_ERRCNT_EN
    exp_err = exp_err + 1;
`endif
    tests++; if (lat !== 32) begin $display("FAIL case2_latency: got %0d, expected 32", lat); fails++; end
    tests++; if (oc !== 1'b0) begin $display("FAIL case2_on_curve: got %b, expected 0", oc); fails++; end
    tests++; if (inv !== 1'b0) begin $display("FAIL case2_invalid: got %b, expected 0", inv); fails++; end
    tests++; if (err_s !== 16'(exp_err)) begin $display("FAIL case2_err_count: got %0d, expected %0d", err_s, exp_err); fails++; end
  endtask

  task automatic test_range_and_infinity;
    int lat; logic oc, inv;
    run_small(8'd23, 8'd5, 1'b0, lat, oc, inv);
    tests++; if (lat !== 2) begin $display("FAIL case3_latency: got %0d, expected 2", lat); fails++; end
    tests++; if (inv !== 1'b1 || oc !== 1'b0) begin
      $display("FAIL case3_results: got invalid=%b on_curve=%b, expected 1 0", inv, oc); fails++; end
    run_small(8'hFF, 8'hFF, 1'b1, lat, oc, inv);
    tests++; if (lat !== 2) begin $display("FAIL case4_latency: got %0d, expected 2", lat); fails++; end
    tests++; if (oc !== 1'b1 || inv !== 1'b0) begin
      $display("FAIL case4_results: got on_curve=%b invalid=%b, expected 1 0", oc, inv); fails++; end
  endtask

  task automatic test_reset_abort;
    int lat; int pulses; logic oc, inv;
    @(negedge clk);
    x_s = 8'd3; y_s = 8'd10; inf_s = 1'b0; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    tests++; if ({busy_s, done_s, on_curve_s, invalid_s} !== 4'b0000 || err_s !== 16'd0) begin
      $display("FAIL abort_outputs: got busy=%b done=%b on_curve=%b invalid=%b err=%0d, expected all 0",
               busy_s, done_s, on_curve_s, invalid_s, err_s); fails++; end
    @(negedge clk) reset = 1'b0;
    exp_err = 0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_s) pulses++;
    end
    tests++; if (pulses !== 0) begin $display("FAIL abort_no_done: got %0d pulses, expected 0", pulses); fails++; end
    run_small(8'd3, 8'd10, 1'b0, lat, oc, inv);
    tests++; if (lat !== 32 || oc !== 1'b1) begin
      $display("FAIL abort_rerun: got latency=%0d on_curve=%b, expected 32 1", lat, oc); fails++; end
  endtask

  task automatic test_back_to_back;
    int pulses; int first;
    @(negedge clk);
    x_s = 8'd3; y_s = 8'd10; inf_s = 1'b0; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    pulses = 0; first = -1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin x_s = 8'd3; y_s = 8'd11; start_s = 1'b1; end
      if (k == 6) start_s = 1'b0;
      if (done_s) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    tests++; if (pulses !== 1) begin $display("FAIL busy_start_pulses: got %0d, expected 1", pulses); fails++; end
    tests++; if (first !== 32 || on_curve_s !== 1'b1) begin
      $display("FAIL busy_start_result: got latency=%0d on_curve=%b, expected 32 1", first, on_curve_s); fails++; end
  endtask

  task automatic test_p521;
    int lat; logic oc;
    p_b = (530'd1 << 521) - 530'd1;
    a_b = p_b - 530'd3;
    b_b = 530'h0051953eb9618e1c9a1f929a21a0b68540eea2da725b99b315f3b8b489918ef109e156193951ec7e937b1652c0bd3bb1bf073573df883d2c34f1ef451fd46b503f00;
    x_b = 530'h00c6858e06b70404e9cd9e3ecb662395b4429c648139053fb521f828af606b4d3dbaa14b5e77efe75928fe1dc127a2ffa8de3348b3c1856a429bf97e7e31c2e5bd66;
    y_b = 530'h011839296a789a3bc0045c8a5fb42c7d1bd998f54449579b446817afbd17273e662c97ee72995ef42640c550b9013fad0761353c7086a272c24088be94769fd16650;
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      if (run == 1) y_b[0] = ~y_b[0];
      start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      lat = -1;
      for (int k = 1; k <= 2000; k++) begin
        @(posedge clk); #1;
        if (done_b) begin lat = k; break; end
      end
      oc = on_curve_b;
      tests++; if (lat !== 1598) begin $display("FAIL p521_latency_%0d: got %0d, expected 1598", run, lat); fails++; end
      tests++; if (oc !== (run == 0) || invalid_b !== 1'b0) begin
        $display("FAIL p521_on_curve_%0d: got on_curve=%b invalid=%b, expected %0d 0", run, oc, invalid_b, run == 0); fails++; end
    end
  endtask

  initial begin
    test_reset();
    test_on_curve();
    test_off_curve();
    test_range_and_infinity();
    test_reset_abort();
    test_back_to_back();
    test_p521();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
